// File: rtl/counter_game_sequencer.sv
// counter_game_sequencer: plays a counter through CLEAR/INIT/RUN from a programmable step table,
// latching the game result and ending a runaway game with a watchdog.
module counter_game_sequencer #(
    parameter int NSTEPS = 4,
    parameter int WDOG   = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_cfg_we,
    input  logic [2:0] i_cfg_addr,
    input  logic [5:0] i_cfg_data,
    input  logic       i_gameover,
    input  logic [1:0] i_who,
    output logic       o_cnt_rst,
    output logic       o_init,
    output logic [3:0] o_load,
    output logic [1:0] o_control,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_result,
    output logic       o_timeout
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_INIT, S_RUN, S_DONE} state_t;

    state_t     r_state;
    logic [5:0] r_step [4];
    logic [3:0] r_load;
    logic [1:0] r_ptr;
    logic [3:0] r_dwell;
    logic [7:0] r_wdog;
    logic [1:0] w_next_ptr;
    logic       w_cfg_ok;

    assign w_next_ptr = (r_ptr == 2'(NSTEPS - 1)) ? 2'd0 : r_ptr + 2'd1;
    assign w_cfg_ok   = i_cfg_we && (r_state == S_IDLE || r_state == S_DONE) && i_cfg_addr <= 3'd4;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) r_step[i] <= '0;
            r_load <= '0;
        end else if (w_cfg_ok) begin
            if (i_cfg_addr[2]) r_load <= i_cfg_data[3:0];
            else r_step[i_cfg_addr[1:0]] <= i_cfg_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_dwell   <= '0;
            r_wdog    <= '0;
            o_cnt_rst <= 1'b1;
            o_init    <= 1'b0;
            o_load    <= '0;
            o_control <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_result  <= '0;
            o_timeout <= 1'b0;
        end else if (i_abort) begin
            r_state   <= S_IDLE;
            o_cnt_rst <= 1'b1;
            o_init    <= 1'b0;
            o_load    <= '0;
            o_control <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_result  <= '0;
            o_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state   <= S_CLEAR;
                        o_cnt_rst <= 1'b0;
                        o_busy    <= 1'b1;
                        o_done    <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_INIT;
                    o_cnt_rst <= 1'b1;
                    o_init    <= 1'b1;
                    o_load    <= r_load;
                    o_control <= r_step[0][5:4];
                    r_ptr     <= '0;
                    r_dwell   <= r_step[0][3:0];
                    r_wdog    <= '0;
                end
                S_INIT: begin
                    r_state <= S_RUN;
                    o_init  <= 1'b0;
                end
                S_RUN: begin
                    // GAMEOVER outranks the watchdog; CONTROL is left frozen on either exit
                    if (i_gameover || r_wdog == 8'(WDOG - 1)) begin
                        r_state   <= S_DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_result  <= i_gameover ? i_who : 2'b00;
                        o_timeout <= !i_gameover;
                    end else begin
                        r_wdog <= r_wdog + 8'd1;
                        if (r_dwell == 4'd0) begin
                            r_ptr     <= w_next_ptr;
                            r_dwell   <= r_step[w_next_ptr][3:0];
                            o_control <= r_step[w_next_ptr][5:4];
                        end else begin
                            r_dwell <= r_dwell - 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_game_sequencer.sv
// tb_counter_game_sequencer: random and directed games scored against a table-walking reference model.
module tb_counter_game_sequencer;
    localparam int NSTEPS = 2;
    localparam int WDOG   = 20;

    typedef struct {
        logic [1:0] result;
        logic       timeout;
        int         cycles;
        logic [1:0] ctrl;
    } game_t;

    logic       clk, rst_n, start, abort, cfg_we, gameover;
    logic [2:0] cfg_addr;
    logic [5:0] cfg_data;
    logic [1:0] who;
    logic       o_cnt_rst, o_init, o_busy, o_done, o_timeout;
    logic [3:0] o_load;
    logic [1:0] o_control, o_result;

    int    n_tests = 0, n_fails = 0;
    int    m_ctrl [4], m_dwell [4], m_load;
    int    ctrl_q [$], load_q [$];
    game_t game_q [$];
    game_t g;
    int    run_cnt = 0;
    logic  prev_done = 1'b0;

    counter_game_sequencer #(.NSTEPS(NSTEPS), .WDOG(WDOG)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
        .i_gameover(gameover), .i_who(who),
        .o_cnt_rst(o_cnt_rst), .o_init(o_init), .o_load(o_load), .o_control(o_control),
        .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_timeout(o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ctrl_of(input int i);
        int lap, p;
        lap = 0;
        for (int j = 0; j < NSTEPS; j++) lap += m_dwell[j] + 1;
        p = i % lap;
        for (int j = 0; j < NSTEPS; j++) begin
            if (p <= m_dwell[j]) return 2'(m_ctrl[j]);
            p -= m_dwell[j] + 1;
        end
        return 2'b00;
    endfunction

    task automatic cfg(input int a, input int d);
        cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = 6'(d);
        @(posedge clk); #1 cfg_we = 1'b0;
        if (a < 4) begin
            m_ctrl[a] = d >> 4;
            m_dwell[a] = d & 15;
        end else if (a == 4) m_load = d & 15;
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("clear_cnt_rst", o_cnt_rst, 0);
        check("clear_busy", o_busy, 1);
        @(posedge clk); #1;
        check("init_strobe", o_init, 1);
        check("init_cnt_rst", o_cnt_rst, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_game(input int go, input logic [1:0] w, input bit wr_run);
        bit hit;
        int n;
        game_t e;
        hit = go > 0 && go <= WDOG;
        n = hit ? go : WDOG;
        load_q.push_back(m_load);
        for (int k = 0; k < n; k++) ctrl_q.push_back(ctrl_of(k));
        e.result = hit ? w : 2'b00;
        e.timeout = !hit;
        e.cycles = n;
        e.ctrl = ctrl_of(n - 1);
        game_q.push_back(e);
        launch();
        for (int k = 1; k <= n; k++) begin
            gameover = (k == go); who = w;
            if (wr_run && k == 2) begin
                cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 6'd9;
            end
            @(posedge clk); #1 gameover = 1'b0; cfg_we = 1'b0;
        end
        check("end_done", o_done, 1);
        check("end_busy", o_busy, 0);
    endtask

    task automatic abort_game(input int k);
        load_q.push_back(m_load);
        for (int j = 0; j < k; j++) ctrl_q.push_back(ctrl_of(j));
        launch();
        for (int j = 1; j <= k; j++) begin
            abort = (j == k); gameover = (j == k); who = 2'b11;
            @(posedge clk); #1 abort = 1'b0; gameover = 1'b0;
        end
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        check("abort_result", o_result, 0);
        check("abort_timeout", o_timeout, 0);
        check("abort_cnt_rst", o_cnt_rst, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cnt_rst"}, o_cnt_rst, 1);
        check({tag, "_init"}, o_init, 0);
        check({tag, "_load"}, o_load, 0);
        check({tag, "_control"}, o_control, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_result"}, o_result, 0);
        check({tag, "_timeout"}, o_timeout, 0);
    endtask

    task automatic reset_mid_run();
        load_q.push_back(m_load);
        for (int k = 0; k < 3; k++) ctrl_q.push_back(ctrl_of(k));
        launch();
        repeat (3) @(posedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_ctrl[i] = 0;
            m_dwell[i] = 0;
        end
        m_load = 0;
    endtask

    always @(negedge clk) begin
        if (o_init) begin
            if (load_q.size() == 0) begin
                n_tests++; n_fails++;
                $display("FAIL init_unexpected: got INIT expected none at %0t", $time);
            end else check("init_load", o_load, load_q.pop_front());
            run_cnt = 0;
        end else if (o_busy && o_cnt_rst) begin
            run_cnt++;
            if (ctrl_q.size() == 0) begin
                n_tests++; n_fails++;
                $display("FAIL run_extra: got RUN cycle expected none at %0t", $time);
            end else check("run_control", o_control, ctrl_q.pop_front());
        end
        if (o_done && !prev_done) begin
            if (game_q.size() == 0) begin
                n_tests++; n_fails++;
                $display("FAIL done_unexpected: got DONE expected none at %0t", $time);
            end else begin
                g = game_q.pop_front();
                check("done_result", o_result, g.result);
                check("done_timeout", o_timeout, g.timeout);
                check("done_run_cycles", run_cnt, g.cycles);
                check("done_control", o_control, g.ctrl);
            end
        end
        prev_done = o_done;
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0; gameover = 1'b0;
        cfg_addr = '0; cfg_data = '0; who = '0;
        for (int i = 0; i < 4; i++) begin
            m_ctrl[i] = 0;
            m_dwell[i] = 0;
        end
        m_load = 0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        cfg(0, 6'h36);
        cfg(1, 6'h22);
        cfg(4, 2);
        run_game(15, 2'b10, 0);
        run_game(0, 2'b11, 0);
        run_game(20, 2'b01, 0);
        run_game(8, 2'b10, 1);
        run_game(3, 2'b01, 0);
        cfg(4, 9);
        run_game(6, 2'b11, 0);
        abort_game(4);
        run_game(5, 2'b10, 0);
        for (int r = 0; r < 8; r++) begin
            repeat (4) cfg($urandom_range(0, 7), $urandom_range(0, 63));
            run_game($urandom_range(1, 26), 2'($urandom_range(0, 3)), 0);
        end
        cfg(4, 5);
        run_game(4, 2'b11, 0);
        reset_mid_run();
        run_game(5, 2'b01, 0);
        repeat (3) @(posedge clk);
        #1;
        check("ctrl_q_drained", ctrl_q.size(), 0);
        check("load_q_drained", load_q.size(), 0);
        check("game_q_drained", game_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule

// File: doc/counter_game_sequencer.md
# counter_game_sequencer

Controller that drives the multi-mode counter's INIT, load and CONTROL inputs from a small programmable step table, restarting and clearing the counter between games. It sits directly upstream of the counter and watches its GAMEOVER/WHO outputs. It latches the game result and enforces a run-length watchdog. Software or a top-level FSM writes the step table, pulses START and reads RESULT when DONE rises.

## Interface
- NSTEPS, 4, number of step-table entries used per lap (1..4)
- WDOG, 255, max RUN cycles before forced timeout (1..255)
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- START  in  1  begin game; sampled in IDLE or DONE only
- ABORT  in  1  abandon game from any state
- CFG_WE  in  1  step-table / load-value write strobe
- CFG_ADDR  in  3  0..3 = step entry, 4 = load value
- CFG_DATA  in  6  step: {CONTROL[1:0], DWELL[3:0]}; load: DATA[3:0]
- GAMEOVER  in  1  from counter
- WHO  in  2  from counter, who ended the game
- CNT_RST  out  1  active-low clear to counter
- INIT  out  1  counter load strobe
- LOAD  out  4  counter load value
- CONTROL  out  2  counter mode
- BUSY  out  1  high in CLEAR/INIT/RUN
- DONE  out  1  high in DONE
- RESULT  out  2  latched WHO at game end
- TIMEOUT  out  1  game ended by watchdog

## Operation
- States: IDLE, CLEAR, INIT, RUN, DONE.
- IDLE: outputs idle; START=1 -> CLEAR.
- CLEAR (1 cycle): CNT_RST=0; -> INIT.
- INIT (1 cycle): INIT=1, LOAD=load register, CONTROL=step[0].CONTROL; step ptr=0, dwell ctr=step[0].DWELL, watchdog=0; -> RUN.
- RUN: CONTROL=step[ptr].CONTROL. Each cycle, dwell ctr decrements. At 0, ptr advances (NSTEPS-1 wraps to 0) and dwell ctr reloads from the new entry. Each entry is therefore active DWELL+1 cycles. Watchdog increments every RUN cycle.
- RUN exit: GAMEOVER=1 -> DONE, RESULT<=WHO, TIMEOUT<=0. Otherwise watchdog==WDOG-1 -> DONE, RESULT<=2'b00, TIMEOUT<=1. If both occur in the same cycle, GAMEOVER wins.
- DONE: CONTROL held at last value; RESULT/TIMEOUT stable; START=1 -> CLEAR (new game).
- ABORT=1 in any state -> IDLE next cycle. ABORT has priority over START and GAMEOVER. RESULT and TIMEOUT are cleared.
- Config writes are accepted only in IDLE or DONE. They are ignored while BUSY. CFG_ADDR 5..7 is ignored.
- Step table and load register live in registers and reset to 0. A step of {0,0} means CONTROL=0 for 1 cycle.

## Timing
- Reset values: state IDLE, CNT_RST=1, INIT=0, LOAD=0, CONTROL=0, BUSY=0, DONE=0, RESULT=0, TIMEOUT=0. All table entries and counters are 0.
- All outputs are registered, with no combinational path from any input to any output.
- START at edge N -> CNT_RST low during N+1..N+2, INIT high during N+2..N+3, RUN from edge N+3.
- GAMEOVER sampled high at edge M -> DONE=1 and RESULT valid from edge M. BUSY falls at the same edge.
- A step change is visible on CONTROL the cycle after the dwell counter reaches 0, with no gap cycle.
- The async RST assertion mid-game forces IDLE immediately. Deassertion is synchronized by the existing reset scheme.
- ptr wrap: with NSTEPS=1, entry 0 repeats indefinitely.

## Test plan
- Reset mid-RUN (RST=0 at any cycle) -> all outputs at reset values immediately; START afterward begins a clean game.
- Table {3,d6},{2,d2}, load=2, NSTEPS=2, START -> CLEAR 1 cycle, INIT 1 cycle with LOAD=2. CONTROL then reads 3 for 7 cycles, 2 for 3 cycles, and repeats.
- Drive GAMEOVER=1 with WHO=2'b10 during RUN -> next edge DONE=1, RESULT=2'b10, TIMEOUT=0, CONTROL frozen.
- WDOG=20, GAMEOVER never asserted -> DONE after exactly 20 RUN cycles, TIMEOUT=1, RESULT=0. GAMEOVER on the expiring cycle gives TIMEOUT=0.
- CFG_WE during RUN (addr 4, data 9) -> ignored. The next game still loads the old value, and a write in DONE takes effect on restart.
- ABORT asserted together with GAMEOVER in RUN -> IDLE, RESULT=0, DONE=0. START in DONE -> new CLEAR/INIT sequence.
